// File: rtl/slot_reel_bank.sv
// Multi-reel slot machine spin counter: one start launches every reel, each reel
// freezes on its own synchronised stop button, and the round reports done/win.

module slot_reel_lane #(
    parameter int          DIGIT_MAX = 9,
    parameter logic [3:0]  OFFSET    = 4'd0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic       run_i,
    input  logic       tick_i,
    input  logic       stop_n_i,
    output logic [3:0] digit_o,
    output logic       spinning_o
);
    logic       s1_q, s2_q, s3_q;
    logic [3:0] digit_q, digit_d;
    logic       spin_q, spin_d;
    logic       stop_ev;

    // Synchronisers idle high so a reset never fakes a button press.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= stop_n_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign stop_ev = s3_q & ~s2_q;

    always_comb begin
        digit_d = digit_q;
        spin_d  = spin_q;
        if (load_i) begin
            digit_d = OFFSET;
            spin_d  = 1'b1;
        end else if (run_i) begin
            // A stop landing on a tick still takes the step before freezing.
            if (tick_i && spin_q)
                digit_d = (digit_q == 4'(DIGIT_MAX)) ? 4'd0 : digit_q + 4'd1;
            if (stop_ev)
                spin_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            digit_q <= 4'd0;
            spin_q  <= 1'b0;
        end else begin
            digit_q <= digit_d;
            spin_q  <= spin_d;
        end
    end

    assign digit_o    = digit_q;
    assign spinning_o = spin_q;
endmodule

module slot_reel_bank #(
    parameter int REELS      = 3,
    parameter int PRESCALE_W = 23,
    parameter int DIGIT_MAX  = 9
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [REELS-1:0]     stop_n_i,
    output logic [4*REELS-1:0]   digits_o,
    output logic [REELS-1:0]     spinning_o,
    output logic                 done_o,
    output logic                 win_o
);
    typedef enum logic [1:0] {IDLE, SPIN, RESULT} state_t;

    state_t                  state_q, state_d;
    logic [PRESCALE_W-1:0]   presc_q, presc_d;
    logic                    load, run, tick, all_eq;
    logic [REELS-1:0][3:0]   dig;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE, RESULT: begin
                if (start_i) begin
                    state_d = SPIN;
                    load    = 1'b1;
                end
            end
            SPIN: begin
                if (spinning_o == '0)
                    state_d = RESULT;
            end
            default: state_d = IDLE;
        endcase
    end

    assign run  = (state_q == SPIN);
    assign tick = run && (presc_q == '1);

    always_comb begin
        presc_d = presc_q;
        if (load)
            presc_d = '0;
        else if (run)
            presc_d = presc_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
        end
    end

    for (genvar g = 0; g < REELS; g++) begin : g_reel
        localparam logic [3:0] OFF = 4'(g % (DIGIT_MAX + 1));
        slot_reel_lane #(
            .DIGIT_MAX (DIGIT_MAX),
            .OFFSET    (OFF)
        ) u_lane (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .load_i     (load),
            .run_i      (run),
            .tick_i     (tick),
            .stop_n_i   (stop_n_i[g]),
            .digit_o    (dig[g]),
            .spinning_o (spinning_o[g])
        );
        assign digits_o[4*g +: 4] = dig[g];
    end

    always_comb begin
        all_eq = 1'b1;
        for (int i = 1; i < REELS; i++)
            if (dig[i] != dig[0])
                all_eq = 1'b0;
    end

    assign done_o = (state_q == RESULT);
    assign win_o  = done_o & all_eq;
endmodule

// File: tb/tb_slot_reel_bank.sv
// Randomised bench for slot_reel_bank: a per-round arithmetic model predicts every
// reel from its start edge and the edge its stop took effect.

module tb_slot_reel_bank;
    localparam int REELS = 3;
    localparam int PW    = 2;
    localparam int DMAX  = 9;
    localparam int PRE   = 1 << PW;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [REELS-1:0]   stop_n;
    logic [4*REELS-1:0] digits;
    logic [REELS-1:0]   spinning;
    logic               done, win;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    slot_reel_bank #(.REELS(REELS), .PRESCALE_W(PW), .DIGIT_MAX(DMAX)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .stop_n_i   (stop_n),
        .digits_o   (digits),
        .spinning_o (spinning),
        .done_o     (done),
        .win_o      (win)
    );

    // Digit after n edges past the start edge for a reel that froze at edge f.
    function automatic int mdig(int i, int n, int f);
        return (i + ((n < f) ? n : f) / PRE) % (DMAX + 1);
    endfunction

    task automatic tick_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick_edge();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] ed;
        rst = 1'b1; start = 1'b0; stop_n = '1;
        repeat (2) tick_edge();
        n_chk++;
        if ({digits, spinning, done, win} !== '0)
            $display("FAIL reset_values got %h/%b/%b/%b want 0", digits, spinning, done, win);
        else n_pass++;
        rst = 1'b0;
        start = 1'b1;
        tick_edge();
        start = 1'b0;
        repeat (10) tick_edge();
        ed = {4'(mdig(2, 10, 999)), 4'(mdig(1, 10, 999)), 4'(mdig(0, 10, 999))};
        n_chk++;
        if (digits !== ed || spinning !== 3'b111)
            $display("FAIL reset_prespin got %h/%b want %h/111", digits, spinning, ed);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({digits, spinning, done, win} !== '0)
            $display("FAIL reset_midspin got %h/%b/%b/%b want 0", digits, spinning, done, win);
        else n_pass++;
        tick_edge();
        rst = 1'b0;
        stop_n[0] = 1'b0;
        repeat (3) tick_edge();
        stop_n = '1;
        repeat (10) tick_edge();
        n_chk++;
        if ({digits, spinning, done, win} !== '0)
            $display("FAIL reset_idle_quiet got %h/%b/%b/%b want 0", digits, spinning, done, win);
        else n_pass++;
    endtask

    task automatic test_wrap();
        start = 1'b1;
        tick_edge();
        start = 1'b0;
        for (int n = 0; n <= 8 * PRE; n++) begin
            if (n == 8 * PRE - 1) begin
                n_chk++;
                if (digits !== 12'h987) $display("FAIL wrap_pre got %h want 987", digits);
                else n_pass++;
            end
            if (n == 8 * PRE) begin
                n_chk++;
                if (digits !== 12'h098) $display("FAIL wrap_post got %h want 098", digits);
                else n_pass++;
            end
            if (n < 8 * PRE) tick_edge();
        end
        do_reset();
    endtask

    task automatic test_stop_latency();
        start = 1'b1;
        tick_edge();
        start = 1'b0;
        for (int n = 0; n < 28; n++) begin
            if (n == 6) begin
                n_chk++;
                if (spinning !== 3'b111) $display("FAIL stop_early got %b want 111", spinning);
                else n_pass++;
            end
            if (n >= 7) begin
                n_chk++;
                if (spinning !== 3'b101 || digits[7:4] !== 4'(mdig(1, n, 7)))
                    $display("FAIL stop_hold n=%0d got %b/%h want 101/%0d",
                             n, spinning, digits[7:4], mdig(1, n, 7));
                else n_pass++;
            end
            if (n == 4) stop_n[1] = 1'b0;
            tick_edge();
        end
        stop_n = '1;
        do_reset();
        repeat (4) tick_edge();
    endtask

    // One full round from IDLE/RESULT; reel i's button is first sampled low at
    // edge start+p[i]; a start pulse is injected mid-spin at edge start+start_at.
    task automatic run_round(input int p0, input int p1, input int p2, input int start_at);
        int p[3];
        int f[3];
        int fmax;
        int ed[3];
        logic [2:0] es;
        logic edn, ew;
        p[0] = p0; p[1] = p1; p[2] = p2;
        fmax = 0;
        for (int i = 0; i < 3; i++) begin
            f[i] = p[i] + 2;
            if (f[i] > fmax) fmax = f[i];
        end
        start = 1'b1;
        for (int i = 0; i < 3; i++) if (p[i] == 0) stop_n[i] = 1'b0;
        tick_edge();
        start = 1'b0;
        for (int n = 0; n <= fmax + 3; n++) begin
            edn = (n >= fmax + 1);
            for (int i = 0; i < 3; i++) begin
                ed[i] = mdig(i, n, f[i]);
                es[i] = (n < f[i]);
            end
            ew = edn && ed[0] == ed[1] && ed[1] == ed[2];
            n_chk++;
            if (digits !== {4'(ed[2]), 4'(ed[1]), 4'(ed[0])})
                $display("FAIL round_digits n=%0d got %h want %0d%0d%0d", n, digits, ed[2], ed[1], ed[0]);
            else n_pass++;
            n_chk++;
            if (spinning !== es) $display("FAIL round_spinning n=%0d got %b want %b", n, spinning, es);
            else n_pass++;
            n_chk++;
            if (done !== edn || win !== ew)
                $display("FAIL round_done_win n=%0d got %b/%b want %b/%b", n, done, win, edn, ew);
            else n_pass++;
            for (int i = 0; i < 3; i++) if (p[i] == n + 1) stop_n[i] = 1'b0;
            start = (n + 1 == start_at);
            tick_edge();
        end
        start = 1'b0;
        stop_n = '1;
        repeat (4) tick_edge();
        for (int i = 0; i < 3; i++) ed[i] = mdig(i, 9999, f[i]);
        n_chk++;
        if (done !== 1'b1 || digits !== {4'(ed[2]), 4'(ed[1]), 4'(ed[0])})
            $display("FAIL result_hold got %b/%h want 1/%0d%0d%0d", done, digits, ed[2], ed[1], ed[0]);
        else n_pass++;
    endtask

    task automatic test_collision();
        run_round(18, 30, 40, -1);
        n_chk++;
        if (digits[3:0] !== 4'd5) $display("FAIL collision got %0d want 5", digits[3:0]);
        else n_pass++;
    endtask

    task automatic test_win();
        run_round(19, 15, 11, -1);
        n_chk++;
        if (win !== 1'b1 || digits !== 12'h555) $display("FAIL win got %b/%h want 1/555", win, digits);
        else n_pass++;
    endtask

    task automatic test_lose_restart();
        run_round(0, 0, 0, 1);
        n_chk++;
        if (win !== 1'b0 || done !== 1'b1 || digits !== 12'h210)
            $display("FAIL lose got %b/%b/%h want 0/1/210", win, done, digits);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++)
            run_round($urandom_range(0, 60), $urandom_range(0, 60), $urandom_range(0, 60),
                      $urandom_range(1, 2));
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_stop_latency();
        test_collision();
        test_win();
        test_lose_restart();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/slot_reel_bank.md
# slot_reel_bank

Parametrised multi-reel spin counter for the 7-segment slot machine. Each of REELS reels holds one decimal digit that cycles 0..DIGIT_MAX at a prescaled rate while spinning. A single start launches all reels; an independent asynchronous, active-low stop button per reel freezes that reel. When every reel has stopped, the block flags the round done and reports a win if all digits match. Digit outputs feed the 7-segment decoder/mux downstream.

## Interface
- REELS, 3, number of reels/digits (1..8)
- PRESCALE_W, 23, prescaler width; one reel step every 2^PRESCALE_W clocks
- DIGIT_MAX, 9, last digit value before wrap to 0 (1..15)
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  synchronous, active-high round start, sampled each edge
- stop_n  in  REELS  asynchronous active-low stop buttons, bit i = reel i
- digits  out  4*REELS  reel i digit in bits [4i+3:4i], unsigned binary
- spinning  out  REELS  bit i high while reel i advances
- done  out  1  high in RESULT state
- win  out  1  high in RESULT when all digits equal

## Operation
- States: IDLE, SPIN, RESULT. Reset -> IDLE.
- Reset values: digits all 0, spinning 0, done 0, win 0, prescaler 0, stop synchronisers all 1.
- IDLE: start=1 -> SPIN at that edge; digit i loads (i mod (DIGIT_MAX+1)); spinning all 1; prescaler cleared to 0.
- SPIN: prescaler increments every clock, wraps mod 2^PRESCALE_W; tick = prescaler == 2^PRESCALE_W-1.
- On tick, each reel with spinning[i]=1 steps: digit == DIGIT_MAX -> 0, else digit+1. Stopped reels hold.
- Stop path per reel: 3-flop chain s1<=stop_n, s2<=s1, s3<=s2; stop event = s3 & ~s2 (falling edge, one cycle). Held-low buttons produce one event only.
- Stop event in SPIN clears spinning[i]. Event on an already-stopped reel: no effect.
- Stop event and tick in same cycle: digit takes the stepped value, spinning[i] clears at the same edge.
- SPIN with spinning == 0 at an edge -> RESULT; done=1; win = all REELS digits equal (REELS=1: win=1).
- RESULT: digits, done, win held. start=1 -> SPIN exactly as from IDLE; done and win clear at that edge.
- start in SPIN ignored. Stop events in IDLE/RESULT ignored (synchronisers still run).
- reset asserted at any time (mid-spin included): immediate return to reset values, no partial update.

## Timing
- start sampled high at edge k: spinning all 1, offsets loaded after edge k.
- First tick: cycle after edge k+2^PRESCALE_W-1; first digit step at edge k+2^PRESCALE_W, then every 2^PRESCALE_W clocks.
- stop_n first sampled low at edge k: event during cycle k+1..k+2; spinning[i] falls after edge k+2.
- Last spinning bit falls after edge m: done and win valid after edge m+1.
- Stop button pulses shorter than one clock may be missed; no debouncing in this block (done upstream).

## Test plan
- Reset: assert reset mid-SPIN with REELS=3 -> all outputs 0 immediately, state IDLE; deassert, no activity without start.
- Spin/wrap: PRESCALE_W=2, DIGIT_MAX=9, start one cycle -> digits 0,1,2; step every 4 clocks; reel 2 goes 9 -> 0 after 8 steps.
- Stop latency: stop_n[1] low at edge k -> spinning=3'b101 after edge k+2, digit 1 frozen; held low 20 cycles gives no further event.
- Tick collision: stop event aligned with tick when reel 0 shows 4 -> reel 0 freezes at 5.
- Win/lose: stop each reel as its digit reads 5 -> done=1, win=1 one cycle after last stop; stop all together at start -> 0,1,2, done=1, win=0.
- Restart/ignore: start in SPIN no effect; start in RESULT -> done=0, win=0, offsets reloaded, spinning=3'b111.
